// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IF/MEM byte-port arbiter.
//   size encodings, FSM state enum, grant enum, transfer payload struct,
//   and the size-to-beat-count mapping.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BEAT_W = 2;
    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

    // Transfer attributes latched at grant
    typedef struct packed {
        logic              rw;
        logic [SIZE_W-1:0] size;
        logic [DATA_W-1:0] wdata;
    } xfer_s;

    // Number of byte beats for an access size; 2'b11 behaves as a word
    function automatic logic [2:0] beat_count(input logic [SIZE_W-1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_beat_steer.sv
// Combinational byte steering for one beat of a big-endian access.
//   size    : access size encoding
//   beat    : beat index within the access
//   wdata   : right-aligned store data
//   wbyte_c : byte of wdata sent on this beat
//   lane_c  : byte lane of the assembled read word filled by this beat
module mem_beat_steer
    import mem_arb_pkg::*;
(
    input  logic [SIZE_W-1:0] size,
    input  logic [BEAT_W-1:0] beat,
    input  logic [DATA_W-1:0] wdata,
    output logic [BYTE_W-1:0] wbyte_c,
    output logic [BEAT_W-1:0] lane_c
);

    // Beat 0 is the most significant byte of the accessed size; out-of-range
    // beats wrap modulo 4, which the caller relies on.
    always_comb begin
        lane_c  = BEAT_W'(beat_count(size) - 3'd1 - {1'b0, beat});
        wbyte_c = wdata[{lane_c, 3'b000} +: BYTE_W];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared byte-wide RAM port between instruction fetch (IF)
// and load/store (MEM); each access is serialized into big-endian byte beats.
//   CLK, CLR                       : clock, async active-high reset
//   if_req/if_addr/if_rdata/if_ready : fetch request and word response
//   mem_req/mem_rw/mem_size/mem_addr/mem_wdata/mem_rdata/mem_ready
//                                  : load/store request and response
//   ram_addr/ram_we/ram_wdata/ram_rdata : byte RAM port (combinational read)
//   stall_if/stall_mem             : requester waiting, to the hazard unit
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    grant_e              gnt_q, gnt_d;
    grant_e              last_q, last_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    xfer_s               req_q, req_d;
    logic [DATA_W-1:0]   acc_q, acc_d;

    logic [ADDR_W-1:0]   ram_addr_d;
    logic                ram_we_d;
    logic [BYTE_W-1:0]   ram_wdata_d;
    logic [DATA_W-1:0]   if_rdata_d, mem_rdata_d;
    logic                if_ready_d, mem_ready_d;

    logic                win_mem;
    logic [SIZE_W-1:0]   st_size;
    logic [BEAT_W-1:0]   st_beat;
    logic [DATA_W-1:0]   st_wdata;
    logic [BYTE_W-1:0]   wbyte_c;
    logic [BEAT_W-1:0]   lane_c;
    logic [BEAT_W-1:0]   rd_lane;
    logic [BEAT_W-1:0]   last_beat;

    logic                unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

    // MEM wins when alone, or on a conflict when IF had the previous grant
    assign win_mem = mem_req && (!if_req || (last_q == GNT_IF));

    // Steering looks one beat ahead so the registered byte lines up with its beat
    always_comb begin
        if (state_q == IDLE) begin
            st_size  = win_mem ? mem_size : SZ_WORD;
            st_beat  = '0;
            st_wdata = win_mem ? mem_wdata : '0;
        end else begin
            st_size  = req_q.size;
            st_beat  = BEAT_W'(cnt_q + 2'd1);
            st_wdata = req_q.wdata;
        end
    end

    mem_beat_steer u_steer (
        .size    (st_size),
        .beat    (st_beat),
        .wdata   (st_wdata),
        .wbyte_c (wbyte_c),
        .lane_c  (lane_c)
    );

    // Lane of the current beat is one above the look-ahead beat's lane
    assign rd_lane   = BEAT_W'(lane_c + 2'd1);
    assign last_beat = BEAT_W'(beat_count(req_q.size) - 3'd1);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        base_d      = base_q;
        req_d       = req_q;
        acc_d       = acc_q;
        ram_addr_d  = ram_addr;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata;
        if_rdata_d  = if_rdata;
        mem_rdata_d = mem_rdata;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    acc_d   = '0;
                    gnt_d   = win_mem ? GNT_MEM : GNT_IF;
                    last_d  = gnt_d;
                    if (win_mem) begin
                        req_d  = xfer_s'{rw: mem_rw, size: mem_size, wdata: mem_wdata};
                        base_d = mem_addr[ADDR_W-1:0];
                    end else begin
                        req_d  = xfer_s'{rw: 1'b0, size: SZ_WORD, wdata: '0};
                        base_d = if_addr[ADDR_W-1:0];
                    end
                    ram_addr_d  = base_d;
                    ram_we_d    = req_d.rw;
                    ram_wdata_d = wbyte_c;
                end
            end
            BUSY: begin
                acc_d[{rd_lane, 3'b000} +: BYTE_W] = ram_rdata;
                if (cnt_q == last_beat) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    if (gnt_q == GNT_MEM) begin
                        mem_rdata_d = acc_d;
                        mem_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = acc_d;
                        if_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d       = BEAT_W'(cnt_q + 2'd1);
                    ram_addr_d  = base_q + ADDR_W'(cnt_d);
                    ram_we_d    = req_q.rw;
                    ram_wdata_d = wbyte_c;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= GNT_IF;
            last_q    <= GNT_IF;
            base_q    <= '0;
            req_q     <= '0;
            acc_q     <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            base_q    <= base_d;
            req_q     <= req_d;
            acc_q     <= acc_d;
            ram_addr  <= ram_addr_d;
            ram_we    <= ram_we_d;
            ram_wdata <= ram_wdata_d;
            if_rdata  <= if_rdata_d;
            mem_rdata <= mem_rdata_d;
            if_ready  <= if_ready_d;
            mem_ready <= mem_ready_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 256x8 RAM model.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req = 1'b0;
    logic        mem_rw = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        stall_if;
    logic        stall_mem;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [256];

    mem_port_arbiter #(.ADDR_W(8)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 CLK = ~CLK;

    assign ram_rdata = ram[ram_addr];
    always @(posedge CLK) if (ram_we) ram[ram_addr] = ram_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h10] = 8'hE3; ram[8'h11] = 8'hA0; ram[8'h12] = 8'h10; ram[8'h13] = 8'h05;
        ram[8'h22] = 8'h12; ram[8'h23] = 8'h34;
        ram[8'hFE] = 8'hAA; ram[8'hFF] = 8'hBB; ram[8'h00] = 8'hCC; ram[8'h01] = 8'hDD;

        // Reset values
        repeat (2) tick();
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        check("rst_if_ready", 32'(if_ready), 32'h0);
        check("rst_mem_ready", 32'(mem_ready), 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        CLR = 1'b0;
        tick();

        // IF word fetch at 0x10
        if_req = 1'b1; if_addr = 32'h0000_0010;
        #1;
        check("f_stall_c0", 32'(stall_if), 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("f_ram_addr", 32'(ram_addr), 32'h10 + 32'(k));
            check("f_ram_we", 32'(ram_we), 32'h0);
            check("f_stall", 32'(stall_if), 32'h1);
            check("f_ready_early", 32'(if_ready), 32'h0);
        end
        tick();
        check("f_ready", 32'(if_ready), 32'h1);
        check("f_rdata", if_rdata, 32'hE3A0_1005);
        if_req = 1'b0;
        #1;
        check("f_stall_drop", 32'(stall_if), 32'h0);
        tick();
        check("f_ready_pulse", 32'(if_ready), 32'h0);

        // MEM halfword store 0xBEEF at 0x20
        mem_req = 1'b1; mem_rw = 1'b1; mem_size = 2'b01;
        mem_addr = 32'h0000_0020; mem_wdata = 32'h0000_BEEF;
        #1;
        check("hs_stall", 32'(stall_mem), 32'h1);
        tick();
        check("hs_we0", 32'(ram_we), 32'h1);
        check("hs_addr0", 32'(ram_addr), 32'h20);
        check("hs_wdata0", 32'(ram_wdata), 32'hBE);
        tick();
        check("hs_we1", 32'(ram_we), 32'h1);
        check("hs_addr1", 32'(ram_addr), 32'h21);
        check("hs_wdata1", 32'(ram_wdata), 32'hEF);
        tick();
        check("hs_ready", 32'(mem_ready), 32'h1);
        check("hs_we_off", 32'(ram_we), 32'h0);
        check("hs_ram20", 32'(ram[8'h20]), 32'hBE);
        check("hs_ram21", 32'(ram[8'h21]), 32'hEF);
        check("hs_ram22", 32'(ram[8'h22]), 32'h12);
        mem_req = 1'b0;
        tick();

        // MEM byte load at 0x21
        mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b00; mem_addr = 32'h0000_0021;
        tick();
        check("bl_we", 32'(ram_we), 32'h0);
        check("bl_ready_early", 32'(mem_ready), 32'h0);
        tick();
        check("bl_ready", 32'(mem_ready), 32'h1);
        check("bl_rdata", mem_rdata, 32'h0000_00EF);
        mem_req = 1'b0;
        tick();

        // Word load at 0x1FE: only the low address byte is used, wraps 0xFF->0x00
        mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 32'h0000_01FE;
        tick();
        check("wr_addr0", 32'(ram_addr), 32'hFE);
        mem_addr = 32'h0000_0040; mem_size = 2'b00;
        tick();
        check("wr_addr1", 32'(ram_addr), 32'hFF);
        tick();
        check("wr_addr2", 32'(ram_addr), 32'h00);
        tick();
        check("wr_addr3", 32'(ram_addr), 32'h01);
        check("wr_ready_early", 32'(mem_ready), 32'h0);
        tick();
        check("wr_ready", 32'(mem_ready), 32'h1);
        check("wr_rdata", mem_rdata, 32'hAABB_CCDD);
        mem_req = 1'b0;
        tick();

        // Size 2'b11 behaves as a word load
        mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b11; mem_addr = 32'h0000_0020;
        repeat (4) tick();
        check("s3_ready_early", 32'(mem_ready), 32'h0);
        tick();
        check("s3_ready", 32'(mem_ready), 32'h1);
        check("s3_rdata", mem_rdata, 32'hBEEF_1234);
        mem_req = 1'b0;
        tick();

        // Round-robin after reset: MEM, then IF, then MEM
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0010;
        mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 32'h0000_0020;
        repeat (5) tick();
        check("rr1_mem_ready", 32'(mem_ready), 32'h1);
        check("rr1_if_ready", 32'(if_ready), 32'h0);
        check("rr1_mem_rdata", mem_rdata, 32'hBEEF_1234);
        check("rr1_stall_if", 32'(stall_if), 32'h1);
        repeat (6) tick();
        check("rr2_if_ready", 32'(if_ready), 32'h1);
        check("rr2_mem_ready", 32'(mem_ready), 32'h0);
        check("rr2_if_rdata", if_rdata, 32'hE3A0_1005);
        check("rr2_stall_mem", 32'(stall_mem), 32'h1);
        repeat (6) tick();
        check("rr3_mem_ready", 32'(mem_ready), 32'h1);
        check("rr3_if_ready", 32'(if_ready), 32'h0);
        check("rr3_if_hold", if_rdata, 32'hE3A0_1005);
        if_req = 1'b0; mem_req = 1'b0;
        tick();

        // Word store at 0x40 aborted by CLR during beat 2
        mem_req = 1'b1; mem_rw = 1'b1; mem_size = 2'b10;
        mem_addr = 32'h0000_0040; mem_wdata = 32'h1122_3344;
        tick();
        tick();
        tick();
        check("ab_we_b2", 32'(ram_we), 32'h1);
        check("ab_addr_b2", 32'(ram_addr), 32'h42);
        check("ab_wdata_b2", 32'(ram_wdata), 32'h33);
        CLR = 1'b1;
        #1;
        check("ab_we_clr", 32'(ram_we), 32'h0);
        check("ab_addr_clr", 32'(ram_addr), 32'h0);
        mem_req = 1'b0;
        tick();
        CLR = 1'b0;
        check("ab_ram40", 32'(ram[8'h40]), 32'h11);
        check("ab_ram41", 32'(ram[8'h41]), 32'h22);
        check("ab_ram42", 32'(ram[8'h42]), 32'h00);
        check("ab_ram43", 32'(ram[8'h43]), 32'h00);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("ab_no_ready", 32'(mem_ready), 32'h0);
        end

        // Arbiter is back in IDLE: a byte load completes in 2 cycles
        mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b00; mem_addr = 32'h0000_0041;
        tick();
        check("pa_ready_early", 32'(mem_ready), 32'h0);
        tick();
        check("pa_ready", 32'(mem_ready), 32'h1);
        check("pa_rdata", mem_rdata, 32'h0000_0022);
        mem_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single byte-wide 256x8 memory port between the IF stage (instruction fetch) and the MEM stage (load/store), serializing each access into byte beats. Word accesses are assembled and split big-endian. The block drives stall outputs to the hazard unit while a requester waits. It sits between the pipeline and the ram module; the ram is the shared resource.

## Interface
- ADDR_W, 8, RAM byte-address width; addresses wrap modulo 2^ADDR_W
- CLK  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-high
- if_req  in  1  IF fetch request, held until if_ready
- if_addr  in  32  fetch byte address; only [ADDR_W-1:0] used
- if_rdata  out  32  fetched word
- if_ready  out  1  one-cycle completion pulse for IF
- mem_req  in  1  MEM access request, held until mem_ready
- mem_rw  in  1  1 = store, 0 = load
- mem_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data, right-aligned
- mem_rdata  out  32  load data, zero-extended
- mem_ready  out  1  one-cycle completion pulse for MEM
- ram_addr  out  ADDR_W  byte address to ram
- ram_we  out  1  byte write strobe
- ram_wdata  out  8  byte to ram
- ram_rdata  in  8  combinational read byte from ram
- stall_if  out  1  if_req & ~if_ready
- stall_mem  out  1  mem_req & ~mem_ready

## Operation
- FSM states:
  - IDLE: sample requests, latch the winner's address, rw, size and wdata.
  - BUSY: issue beats 0..N-1, 2-bit beat counter.
  - RESP: ready pulse.
- Beat count N: IF always 4; MEM 1/2/4 per mem_size.
- Arbitration when both request in IDLE: round-robin on the last_grant flag, so the non-last-granted requester wins. When only one requests, it wins.
- Beat k addresses base+k. The carry drops at ADDR_W, so 0xFF+1 wraps to 0x00. Misaligned addresses are legal; there is no fault.
- Read assembly, big-endian: beat 0 is the most significant byte of the accessed size. Halfword result is {b0,b1} in [15:0]; byte result is b0 in [7:0]. Upper bits are zero.
- Write split: word beats send wdata[31:24], [23:16], [15:8], [7:0]. Halfword beats send [15:8], [7:0]. Byte sends [7:0].
- ram_we is high only during BUSY beats of a store. It is 0 for all loads and fetches.
- Inputs are latched at grant. Requester changes or a dropped req mid-transaction have no effect; the transaction completes and ready still pulses.
- if_rdata and mem_rdata hold their value until that requester's next completion.
- The non-granted requester stays stalled.

## Timing
- Cycle 0 (IDLE, req high) → cycles 1..N: BUSY beats, with ram_rdata captured at each edge → cycle N+1: RESP, ready=1 with rdata valid → cycle N+2: IDLE.
- Word latency is 5 cycles from request to ready. Byte latency is 2 cycles.
- The minimum spacing between grants is N+2 cycles.
- A requester deasserts req in the ready cycle, or the same request re-arbitrates in the next IDLE.
- Reset values: state=IDLE, counter=0, last_grant=IF (MEM wins the first conflict).
- Reset values of outputs: if_ready=0, mem_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, mem_rdata=0.
- CLR asserted mid-transaction aborts immediately. Partial store bytes already written remain in ram, and no ready pulse occurs.
- In IDLE and RESP: ram_addr holds its last value, ram_we=0.

## Structure
- Shared package mem_arb_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum IDLE, BUSY, RESP
  - grant enum GNT_IF, GNT_MEM
  - a function mapping size to beat count
- Sub-module mem_beat_steer is purely combinational. It takes size, beat index and wdata, and produces the write byte and the read lane position.
- The FSM, counter, arbitration and assembly registers stay in mem_port_arbiter.

## Test plan
- IF fetch, word at 0x10 = 0xE3A01005 → ram_addr 0x10..0x13 over cycles 1-4; if_ready in cycle 5 with if_rdata=0xE3A01005; stall_if high cycles 0-4.
- MEM halfword store 0x0000BEEF at 0x20 → ram_we high 2 cycles; writes 0xBE@0x20, 0xEF@0x21; mem_ready in cycle 3.
- MEM byte load at 0x21 after the previous store → mem_rdata=0x000000EF; mem_ready in cycle 2.
- Both request from reset → MEM granted first. Both request again in the next IDLE → IF granted. Both request again → MEM granted.
- Word load at 0xFE → beats at 0xFE, 0xFF, 0x00, 0x01.
- CLR pulsed in beat 2 of a word store → state IDLE, ram_we=0, no mem_ready. Bytes 0-1 written; bytes 2-3 not written.
